census_disparity_scheduler: RTL

//  Sequences a single pipelined popcount unit over all candidate disparities for one left-image census vector.

---
 rtl/stereo_pkg.sv | 11 +
 rtl/census_popcount_pipe.sv | 76 +++++++
 rtl/census_disparity_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stereo_pkg.sv
// Shared constants and FSM state type for the census disparity search.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stereo_pkg;
  localparam int CENSUS_W = 20;
  localparam int MAX_DISP = 16;
  localparam int DISP_W   = 4;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/census_popcount_pipe.sv
// Two-stage registered popcount of a census XOR vector with valid and disparity tag.
// Latency: 2 cycles from in_valid to out_valid.
// Backpressure: none; the pipe always advances.
module census_popcount_pipe
  import stereo_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DISP_W-1:0]   in_tag,
  input  logic [CENSUS_W-1:0] in_vec,
  output logic                out_valid,
  output logic [DISP_W-1:0]   out_tag,
  output logic [CNT_W-1:0]    out_cnt
);
  localparam int NIB   = (CENSUS_W + 3) / 4;
  localparam int PAD_W = NIB * 4;

  // Bit count of one nibble: pairwise subtract trick, then add the two pair counts.
  function automatic logic [2:0] nib_count(input logic [3:0] n);
    logic [3:0] p;
    p = n - ((n >> 1) & 4'b0101);
    return {1'b0, p[1:0]} + {1'b0, p[3:2]};
  endfunction

  logic [PAD_W-1:0]        vec_pad;
  logic [NIB-1:0][2:0]     nib_cnt_d;
  logic [NIB-1:0][2:0]     s1_cnt;
  logic                    s1_valid;
  logic [DISP_W-1:0]       s1_tag;
  logic [CNT_W-1:0]        sum_d;

  assign vec_pad = PAD_W'(in_vec);

  // Stage 1 combinational: per-nibble counts.
  always_comb begin
    nib_cnt_d = '0;
    for (int i = 0; i < NIB; i++) begin
      nib_cnt_d[i] = nib_count(vec_pad[i*4 +: 4]);
    end
  end

  // Stage 1 register: nibble counts plus valid/tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_cnt   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_tag   <= in_tag;
      s1_cnt   <= nib_cnt_d;
    end
  end

  // Stage 2 combinational: fold the nibble counts into one cost.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NIB; i++) begin
      sum_d = sum_d + CNT_W'(s1_cnt[i]);
    end
  end

  // Stage 2 register: final cost plus valid/tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_cnt   <= '0;
    end else begin
      out_valid <= s1_valid;
      out_tag   <= s1_tag;
      out_cnt   <= sum_d;
    end
  end
endmodule

// File: rtl/census_disparity_scheduler.sv
// Searches all disparities for one left census vector and returns the min-cost disparity.
// Latency: result_valid first high in the 19th cycle after the accept cycle (MAX_DISP+3).
// Backpressure: result held in DONE until result_ready; start_ready only in IDLE.
// Optional feature macro: CENSUS_AMBIG_EN adds the best_ambig output.
module census_disparity_scheduler
  import stereo_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [CENSUS_W-1:0]          left_census,
  input  logic [MAX_DISP*CENSUS_W-1:0] right_window,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [DISP_W-1:0]            best_disp,
  output logic [CNT_W-1:0]             best_cost,
  output logic                         busy
`ifdef CENSUS_AMBIG_EN
  ,
  output logic                         best_ambig
`endif
);
  localparam logic [DISP_W-1:0] LAST_D = DISP_W'(MAX_DISP - 1);

  state_t                       state_q, state_d;
  logic [CENSUS_W-1:0]          left_q;
  logic [MAX_DISP*CENSUS_W-1:0] right_q;
  logic [DISP_W-1:0]            d_q;
  logic                         drain_q;
  logic [DISP_W-1:0]            best_disp_q;
  logic [CNT_W-1:0]             best_cost_q;
  logic                         ambig_q;

  logic                         pipe_in_valid;
  logic [CENSUS_W-1:0]          pipe_in_vec;
  logic                         pipe_out_valid;
  logic [DISP_W-1:0]            pipe_out_tag;
  logic [CNT_W-1:0]             pipe_out_cnt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DRAIN waits out the two pipe stages.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid)   state_d = ISSUE;
      ISSUE:   if (d_q == LAST_D) state_d = DRAIN;
      DRAIN:   if (drain_q)       state_d = DONE;
      DONE:    if (result_ready)  state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Job capture, issue counter and drain counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_q  <= '0;
      right_q <= '0;
      d_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            left_q  <= left_census;
            right_q <= right_window;
            d_q     <= '0;
          end
        end
        ISSUE: begin
          drain_q <= 1'b0;
          if (d_q != LAST_D) d_q <= d_q + 1'b1;
        end
        DRAIN:   drain_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign pipe_in_valid = (state_q == ISSUE);
  assign pipe_in_vec   = left_q ^ right_q[d_q*CENSUS_W +: CENSUS_W];

  census_popcount_pipe u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pipe_in_valid),
    .in_tag    (d_q),
    .in_vec    (pipe_in_vec),
    .out_valid (pipe_out_valid),
    .out_tag   (pipe_out_tag),
    .out_cnt   (pipe_out_cnt)
  );

  // Running minimum: tag 0 seeds, strict less-than keeps the lowest disparity on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_disp_q <= '0;
      best_cost_q <= '0;
      ambig_q     <= 1'b0;
    end else if (pipe_out_valid) begin
      if (pipe_out_tag == '0 || pipe_out_cnt < best_cost_q) begin
        best_disp_q <= pipe_out_tag;
        best_cost_q <= pipe_out_cnt;
        ambig_q     <= 1'b0;
      end else if (pipe_out_cnt == best_cost_q) begin
        ambig_q     <= 1'b1;
      end
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign best_disp    = best_disp_q;
  assign best_cost    = best_cost_q;

`ifdef CENSUS_AMBIG_EN
  assign best_ambig = ambig_q;
`else
  logic unused_ambig;
  assign unused_ambig = ambig_q;
`endif
endmodule
